msg_schedule: RTL and testbench

- Producer side of the HCU word stream.
- Accepts padded message blocks as 16 words per block over AXI-Stream and expands each block into the full W_t schedule: 64 words for SHA-224/256, 80 words for SHA-384/512.
- Emits W_t one per cycle on an AXI-Stream master that connects directly to the HCU slave port. The output stream carries tuser and tlast with the same meaning the HCU consumes.

---
 rtl/msg_schedule_pkg.sv | 31 +++
 rtl/msg_schedule_small_sigma.sv | 31 +++
 rtl/msg_schedule.sv | 198 +++++++++++++++++++
 tb/tb_msg_schedule.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_schedule_pkg.sv
// Shared types and constants for the SHA-2 message schedule expander.
package msg_schedule_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2
  } state_e;

  localparam int unsigned WORD_W            = 64;
  localparam int unsigned HALF_W            = 32;
  localparam int unsigned TUSER_W           = 128;
  localparam int unsigned T_W               = 7;
  localparam int unsigned WIN_DEPTH         = 16;
  localparam int unsigned N_ROUNDS_32       = 64;
  localparam int unsigned N_ROUNDS_64       = 80;
  localparam int unsigned TUSER_SLOT_OFFSET = 32;
  localparam int unsigned TUSER_SLOT_WIDTH  = 16;

  // sha_type[1] of the tuser slot selects the 64-bit family.
  function automatic logic slot_is_64(input logic [TUSER_SLOT_WIDTH-1:0] slot);
    return (slot & TUSER_SLOT_WIDTH'(2)) != '0;
  endfunction

  // In 32-bit mode only the low half of a word carries data.
  function automatic logic [WORD_W-1:0] fit_word(input logic mode64,
                                                 input logic [WORD_W-1:0] w);
    return mode64 ? w : {HALF_W'(0), w[HALF_W-1:0]};
  endfunction

endpackage

// File: rtl/msg_schedule_small_sigma.sv
// Combinational small sigma for SHA-256 / SHA-512, family selected by mode64.
module small_sigma
  import msg_schedule_pkg::*;
#(
  parameter int unsigned ROT32_A = 7,
  parameter int unsigned ROT32_B = 18,
  parameter int unsigned SHR32   = 3,
  parameter int unsigned ROT64_A = 1,
  parameter int unsigned ROT64_B = 8,
  parameter int unsigned SHR64   = 7
) (
  input  logic              mode64,
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y_c
);

  logic [2*HALF_W-1:0] dbl32;
  logic [2*WORD_W-1:0] dbl64;
  logic [HALF_W-1:0]   r32;
  logic [WORD_W-1:0]   r64;

  // Rotates are taken from a doubled copy of the operand.
  always_comb begin
    dbl32 = {x[HALF_W-1:0], x[HALF_W-1:0]};
    dbl64 = {x, x};
    r32   = HALF_W'(dbl32 >> ROT32_A) ^ HALF_W'(dbl32 >> ROT32_B) ^ (x[HALF_W-1:0] >> SHR32);
    r64   = WORD_W'(dbl64 >> ROT64_A) ^ WORD_W'(dbl64 >> ROT64_B) ^ (x >> SHR64);
    y_c   = mode64 ? r64 : {HALF_W'(0), r32};
  end

endmodule

// File: rtl/msg_schedule.sv
// Expands 16-word padded blocks into the W_t schedule (64 or 80 words) for the HCU.
// Optional build macro MSG_SCHEDULE_ERR_EN adds a sticky err_tlast flag for misplaced tlast.
module msg_schedule
  import msg_schedule_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 64,
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 64,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axis_aclk,
  input  logic                            reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
`ifdef MSG_SCHEDULE_ERR_EN
  output logic                            err_tlast,
`endif
  output logic                            m_axis_tlast
);

  state_e              state_q, state_d;
  logic [T_W-1:0]      t_q, t_d;
  logic                last_blk_q, last_blk_d;
  logic                mode64_q, mode64_d;
  logic [TUSER_W-1:0]  tuser_q, tuser_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                tlast_q, tlast_d;
  logic [WORD_W-1:0]   win_q [WIN_DEPTH];
  logic [WORD_W-1:0]   win_d [WIN_DEPTH];

  logic                can_load_c;
  logic                s_ready_c;
  logic                accept_c;
  logic                in_mode64_c;
  logic [T_W-1:0]      t_final_c;
  logic                load_word_c;
  logic [WORD_W-1:0]   word_c;
  logic [WORD_W-1:0]   sig0_c, sig1_c;

  assign can_load_c  = !valid_q || m_axis_tready;
  assign s_ready_c   = (state_q != EXPAND) && can_load_c && !reset;
  assign accept_c    = s_axis_tvalid && s_ready_c;
  assign in_mode64_c = slot_is_64(s_axis_tuser[TUSER_SLOT_OFFSET +: TUSER_SLOT_WIDTH]);
  assign t_final_c   = mode64_q ? T_W'(N_ROUNDS_64 - 1) : T_W'(N_ROUNDS_32 - 1);

  // sigma0 taps W[t-15], sigma1 taps W[t-2]; window index 15 holds W[t-1].
  small_sigma #(
    .ROT32_A(7),  .ROT32_B(18), .SHR32(3),
    .ROT64_A(1),  .ROT64_B(8),  .SHR64(7)
  ) u_sigma0 (
    .mode64 (mode64_q),
    .x      (win_q[1]),
    .y_c    (sig0_c)
  );

  small_sigma #(
    .ROT32_A(17), .ROT32_B(19), .SHR32(10),
    .ROT64_A(19), .ROT64_B(61), .SHR64(6)
  ) u_sigma1 (
    .mode64 (mode64_q),
    .x      (win_q[14]),
    .y_c    (sig1_c)
  );

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    last_blk_d  = last_blk_q;
    mode64_d    = mode64_q;
    tuser_d     = tuser_q;
    data_d      = data_q;
    valid_d     = valid_q;
    tlast_d     = tlast_q;
    win_d       = win_q;
    load_word_c = 1'b0;
    word_c      = '0;

    if (can_load_c) begin
      valid_d = 1'b0;
      tlast_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          tuser_d     = s_axis_tuser;
          mode64_d    = in_mode64_c;
          word_c      = fit_word(in_mode64_c, s_axis_tdata);
          load_word_c = 1'b1;
          t_d         = T_W'(1);
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (accept_c) begin
          word_c      = fit_word(mode64_q, s_axis_tdata);
          load_word_c = 1'b1;
          t_d         = t_q + T_W'(1);
          if (t_q == T_W'(WIN_DEPTH - 1)) begin
            last_blk_d = s_axis_tlast;
            state_d    = EXPAND;
          end
        end
      end
      EXPAND: begin
        if (can_load_c) begin
          word_c      = fit_word(mode64_q, sig1_c + win_q[9] + sig0_c + win_q[0]);
          load_word_c = 1'b1;
          t_d         = t_q + T_W'(1);
          if (t_q == t_final_c) begin
            t_d = '0;
            if (last_blk_q) begin
              tlast_d    = 1'b1;
              last_blk_d = 1'b0;
              state_d    = IDLE;
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Window and output register advance together, so a stall freezes both.
    if (load_word_c) begin
      data_d  = word_c;
      valid_d = 1'b1;
      for (int i = 0; i < WIN_DEPTH - 1; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[WIN_DEPTH-1] = word_c;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      state_q    <= IDLE;
      t_q        <= '0;
      last_blk_q <= 1'b0;
      mode64_q   <= 1'b0;
      tuser_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      tlast_q    <= 1'b0;
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      last_blk_q <= last_blk_d;
      mode64_q   <= mode64_d;
      tuser_q    <= tuser_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      tlast_q    <= tlast_d;
      win_q      <= win_d;
    end
  end

`ifdef MSG_SCHEDULE_ERR_EN
  logic err_q, err_d;

  // Sticky: tlast accepted anywhere but the 16th beat of a block.
  always_comb begin
    err_d = err_q;
    if (accept_c && s_axis_tlast && (t_q != T_W'(WIN_DEPTH - 1))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_tlast = err_q;
`endif

  assign s_axis_tready = s_ready_c;
  assign m_axis_tdata  = data_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_msg_schedule.sv
// Directed bench for msg_schedule: SHA-256/512 "abc", two-block, stalls, reset, stray tlast.
module tb_msg_schedule;

  logic          axis_aclk = 1'b0;
  logic          reset;
  logic [63:0]   s_axis_tdata;
  logic [127:0]  s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [63:0]   m_axis_tdata;
  logic [127:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
`ifdef MSG_SCHEDULE_ERR_EN
  logic          err_tlast;
`endif

  int total = 0;
  int bad   = 0;

  logic [63:0]  blk   [16];
  logic [63:0]  exp_w [256];
  logic [63:0]  got_w [256];
  logic         got_l [256];
  logic [127:0] got_u [256];
  int           got_n;

  localparam logic [127:0] U256  = 128'hCAFE0000_00000000_00000000_0000BEEF;
  localparam logic [127:0] U512  = 128'h00000000_00000000_00000002_00000007;
  localparam logic [127:0] U_A   = 128'hA5A5A5A5_00000000_00000001_5A5A5A5A;
  localparam logic [127:0] U_B   = 128'h11111111_22222222_00000002_33333333;

  always #5 axis_aclk = ~axis_aclk;

  msg_schedule dut (
    .axis_aclk     (axis_aclk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
`ifdef MSG_SCHEDULE_ERR_EN
    .err_tlast     (err_tlast),
`endif
    .m_axis_tlast  (m_axis_tlast)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference schedule of the block in blk[], written to exp_w[base..].
  task automatic build(input bit m64, input int base);
    logic [63:0] w [80];
    logic [31:0] a, b, c, d;
    int n;
    n = m64 ? 80 : 64;
    for (int i = 0; i < 16; i++) w[i] = m64 ? blk[i] : {32'h0, blk[i][31:0]};
    for (int i = 16; i < n; i++) begin
      if (m64) begin
        w[i] = (ror64(w[i-2], 19) ^ ror64(w[i-2], 61) ^ (w[i-2] >> 6)) + w[i-7]
             + (ror64(w[i-15], 1) ^ ror64(w[i-15], 8) ^ (w[i-15] >> 7)) + w[i-16];
      end else begin
        a = w[i-2][31:0];
        b = w[i-15][31:0];
        c = ror32(a, 17) ^ ror32(a, 19) ^ (a >> 10);
        d = ror32(b, 7) ^ ror32(b, 18) ^ (b >> 3);
        w[i] = {32'h0, c + w[i-7][31:0] + d + w[i-16][31:0]};
      end
    end
    for (int i = 0; i < n; i++) exp_w[base + i] = w[i];
  endtask

  task automatic send_block(input logic [127:0] u, input logic [15:0] last_mask);
    logic acc;
    int   cyc;
    for (int i = 0; i < 16; i++) begin
      acc = 1'b0;
      cyc = 0;
      s_axis_tdata  = blk[i];
      s_axis_tuser  = u;
      s_axis_tlast  = last_mask[i];
      s_axis_tvalid = 1'b1;
      while (!acc && cyc < 4000) begin
        @(negedge axis_aclk);
        acc = s_axis_tready;
        @(posedge axis_aclk);
        #1;
        cyc++;
      end
      check("send_accept", acc, 1);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic collect(input int n, input int stall_pct);
    logic        prev_stall;
    logic [63:0] prev_d;
    int          cyc;
    prev_stall = 1'b0;
    prev_d     = '0;
    cyc        = 0;
    got_n      = 0;
    while (got_n < n && cyc < 6000) begin
      m_axis_tready = ($urandom_range(99) >= stall_pct);
      @(negedge axis_aclk);
      if (prev_stall) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_data", m_axis_tdata, prev_d);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_w[got_n] = m_axis_tdata;
        got_l[got_n] = m_axis_tlast;
        got_u[got_n] = m_axis_tuser;
        got_n++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
      @(posedge axis_aclk);
      #1;
      cyc++;
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic verify(input string tag, input int n, input logic [127:0] u);
    check({tag, "_count"}, got_n, n);
    for (int i = 0; i < n && i < got_n; i++) begin
      check({tag, "_data"}, got_w[i], exp_w[i]);
      check({tag, "_last"}, got_l[i], (i == n - 1));
      check({tag, "_user"}, got_u[i], u);
    end
  endtask

  task automatic load_abc(input bit m64);
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = m64 ? 64'h6162638000000000 : 64'h0000000061626380;
    blk[15] = 64'h18;
  endtask

  initial begin
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge axis_aclk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_sready", s_axis_tready, 0);
`ifdef MSG_SCHEDULE_ERR_EN
    check("rst_err", err_tlast, 0);
`endif
    reset = 1'b0;
    @(posedge axis_aclk);
    #1;

    // SHA-256 "abc"
    load_abc(1'b0);
    build(1'b0, 0);
    fork
      send_block(U256, 16'h8000);
      collect(64, 0);
    join
    check("abc256_w0", got_w[0], 64'h0000000061626380);
    check("abc256_w16", got_w[16], 64'h0000000061626380);
    check("abc256_w17", got_w[17], 64'h00000000000F0000);
    verify("abc256", 64, U256);

    // SHA-512 "abc"
    load_abc(1'b1);
    build(1'b1, 0);
    fork
      send_block(U512, 16'h8000);
      collect(80, 0);
    join
    check("abc512_w0", got_w[0], 64'h6162638000000000);
    check("abc512_w16", got_w[16], 64'h6162638000000000);
    check("abc512_w17", got_w[17], 64'h00030000000000C0);
    verify("abc512", 80, U512);

    // Two-block SHA-256; second block carries a different tuser and dirty upper bits
    for (int i = 0; i < 16; i++)
      blk[i] = {32'hFFFF0000 | 32'(i), 32'h6a09e667 ^ (32'(i) * 32'h01010101)};
    build(1'b0, 0);
    for (int i = 0; i < 16; i++)
      blk[i] = {32'h12345678, 32'hbb67ae85 + 32'(i) * 32'h9e3779b9};
    build(1'b0, 64);
    fork
      begin
        for (int i = 0; i < 16; i++)
          blk[i] = {32'hFFFF0000 | 32'(i), 32'h6a09e667 ^ (32'(i) * 32'h01010101)};
        send_block(U_A, 16'h0000);
        for (int i = 0; i < 16; i++)
          blk[i] = {32'h12345678, 32'hbb67ae85 + 32'(i) * 32'h9e3779b9};
        send_block(U_B, 16'h8000);
      end
      collect(128, 0);
    join
    verify("two_blk", 128, U_A);

    // SHA-256 "abc" with 30% output stalls
    load_abc(1'b0);
    build(1'b0, 0);
    fork
      send_block(U256, 16'h8000);
      collect(64, 30);
    join
    verify("stall256", 64, U256);

    // Reset mid-expansion, then a fresh message
    fork
      send_block(U256, 16'h8000);
      collect(40, 0);
    join
    check("pre_rst_count", got_n, 40);
    for (int i = 0; i < got_n; i++) check("pre_rst_data", got_w[i], exp_w[i]);
    reset = 1'b1;
    @(posedge axis_aclk);
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_tdata", m_axis_tdata, 0);
    check("mid_rst_tlast", m_axis_tlast, 0);
    check("mid_rst_tuser", m_axis_tuser, 0);
    reset = 1'b0;
    @(posedge axis_aclk);
    #1;
    fork
      send_block(U256, 16'h8000);
      collect(64, 0);
    join
    check("post_rst_w16", got_w[16], 64'h0000000061626380);
    check("post_rst_w17", got_w[17], 64'h00000000000F0000);
    verify("post_rst", 64, U256);

    // Stray tlast on beat 7: block still completes as 64 words
`ifdef MSG_SCHEDULE_ERR_EN
    check("err_before", err_tlast, 0);
`endif
    fork
      send_block(U256, 16'h8080);
      collect(64, 0);
    join
    verify("early_last", 64, U256);
`ifdef MSG_SCHEDULE_ERR_EN
    check("err_after", err_tlast, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
